// File: rtl/fp_mul_mantissa_iter.sv
// Iterative mantissa/exponent multiply for positive single-precision floats.
// Latency: result ready N = 24/RADIX_BITS cycles after the accepting edge.
// Backpressure: accepts only in IDLE; result held in DONE until backprn=1.
module fp_mul_mantissa_iter #(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [30:0] float_in_a,
  input  logic [30:0] float_in_b,
  input  logic [30:0] float_in_2,
  input  logic        error_in,
  input  logic        backprn,
  output logic        backprn_out,
  output logic [47:0] M_out_mul,
  output logic [7:0]  E_out_mul,
  output logic [30:0] float_out_2,
  output logic        ready,
  output logic        error_out
);

  localparam int N  = 24 / RADIX_BITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [23:0]    ma_q, ma_d;
  logic [23:0]    mb_q, mb_d;
  logic [47:0]    acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     e_q, e_d;
  logic           err_q, err_d;
  logic [30:0]    f2_q, f2_d;
  logic [47:0]    m_out_q, m_out_d;
  logic [7:0]     e_out_q, e_out_d;
  logic [30:0]    f2_out_q, f2_out_d;
  logic           ready_q, ready_d;
  logic           err_out_q, err_out_d;

  logic [7:0]        ea, eb;
  logic signed [9:0] e_sum;
  logic              local_err;
  logic [5:0]        shamt;
  logic [47:0]       partial;
  logic [47:0]       acc_next;
  logic              last_step;

  // Exponent sum, range check and the current radix partial product
  always_comb begin
    ea        = float_in_a[30:23];
    eb        = float_in_b[30:23];
    e_sum     = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd254;
    local_err = (ea == 8'h00) || (eb == 8'h00) || (ea == 8'hFF) || (eb == 8'hFF) ||
                (e_sum < -10'sd126) || (e_sum > 10'sd126);
    shamt     = 6'(int'(cnt_q) * RADIX_BITS);
    partial   = (48'(mb_q[RADIX_BITS-1:0]) * 48'(ma_q)) << shamt;
    acc_next  = acc_q + partial;
    last_step = (cnt_q == CW'(N - 1));
  end

  // Next-state logic for the IDLE -> BUSY -> DONE -> IDLE sequence
  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    e_d       = e_q;
    err_d     = err_q;
    f2_d      = f2_q;
    m_out_d   = m_out_q;
    e_out_d   = e_out_q;
    f2_out_d  = f2_out_q;
    ready_d   = ready_q;
    err_out_d = err_out_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          ma_d    = {1'b1, float_in_a[22:0]};
          mb_d    = {1'b1, float_in_b[22:0]};
          acc_d   = '0;
          cnt_d   = '0;
          e_d     = e_sum[7:0];
          err_d   = error_in | local_err;
          f2_d    = float_in_2;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Full multiply runs even for flagged operands so timing never varies
        acc_d = acc_next;
        mb_d  = mb_q >> RADIX_BITS;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          m_out_d   = acc_next;
          e_out_d   = e_q;
          f2_out_d  = f2_q;
          err_out_d = err_q;
          ready_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Outputs stay frozen until downstream takes the result
        if (backprn) begin
          ready_d   = 1'b0;
          err_out_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any product in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      e_q       <= '0;
      err_q     <= 1'b0;
      f2_q      <= '0;
      m_out_q   <= '0;
      e_out_q   <= '0;
      f2_out_q  <= '0;
      ready_q   <= 1'b0;
      err_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      e_q       <= e_d;
      err_q     <= err_d;
      f2_q      <= f2_d;
      m_out_q   <= m_out_d;
      e_out_q   <= e_out_d;
      f2_out_q  <= f2_out_d;
      ready_q   <= ready_d;
      err_out_q <= err_out_d;
    end
  end

  assign backprn_out = (state_q == IDLE);
  assign M_out_mul   = m_out_q;
  assign E_out_mul   = e_out_q;
  assign float_out_2 = f2_out_q;
  assign ready       = ready_q;
  assign error_out   = err_out_q;

endmodule

// File: tb/tb_fp_mul_mantissa_iter.sv
// Bench for fp_mul_mantissa_iter: radix-1 directed vectors, reset abort, radix-4 random.
// Expected results are queued at drive time and popped when ready is seen.
// Each result is held at DONE for a per-vector number of stall cycles.
module tb_fp_mul_mantissa_iter;

  typedef struct {
    logic [30:0] a;
    logic [30:0] b;
    logic [30:0] f2;
    logic        err_in;
    logic [47:0] m;
    logic [7:0]  e;
    logic        err;
    int          hold;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        vld  [2];
  logic [30:0] fa   [2];
  logic [30:0] fb   [2];
  logic [30:0] f2i  [2];
  logic        ei   [2];
  logic        bp   [2];
  logic        bpo  [2];
  logic [47:0] mo   [2];
  logic [7:0]  eo   [2];
  logic [30:0] f2o  [2];
  logic        rdy  [2];
  logic        erro [2];

  int   tests;
  int   fails;
  vec_t sb[$];
  vec_t tbl[10];

  fp_mul_mantissa_iter #(.RADIX_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .valid(vld[0]), .float_in_a(fa[0]), .float_in_b(fb[0]),
    .float_in_2(f2i[0]), .error_in(ei[0]), .backprn(bp[0]), .backprn_out(bpo[0]),
    .M_out_mul(mo[0]), .E_out_mul(eo[0]), .float_out_2(f2o[0]), .ready(rdy[0]),
    .error_out(erro[0])
  );

  fp_mul_mantissa_iter #(.RADIX_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .valid(vld[1]), .float_in_a(fa[1]), .float_in_b(fb[1]),
    .float_in_2(f2i[1]), .error_in(ei[1]), .backprn(bp[1]), .backprn_out(bpo[1]),
    .M_out_mul(mo[1]), .E_out_mul(eo[1]), .float_out_2(f2o[1]), .ready(rdy[1]),
    .error_out(erro[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [30:0] a, input logic [30:0] b, input logic err_in,
                              input logic [47:0] m, input logic [7:0] e, input logic err,
                              input int hold);
    vec_t v;
    v.a = a; v.b = b; v.f2 = 31'($urandom); v.err_in = err_in;
    v.m = m; v.e = e; v.err = err; v.hold = hold;
    return v;
  endfunction

  // Drive one operand pair into DUT d, wait for its result, check, then release it
  task automatic run(input int d, input vec_t v, input int exp_lat);
    vec_t ex;
    int   lat;
    sb.push_back(v);
    @(negedge clk);
    fa[d] = v.a; fb[d] = v.b; f2i[d] = v.f2; ei[d] = v.err_in;
    bp[d] = (v.hold == 0);
    vld[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[d] = 1'b0; fa[d] = '0; fb[d] = '0; f2i[d] = '0; ei[d] = 1'b0;
    chk("busy_backprn_out", 64'(bpo[d]), 64'd0);
    lat = 0;
    while (!rdy[d] && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 200) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready", lat);
      void'(sb.pop_front());
      bp[d] = 1'b1;
      return;
    end
    ex = sb.pop_front();
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("M_out_mul", 64'(mo[d]), 64'(ex.m));
    chk("error_out", 64'(erro[d]), 64'(ex.err));
    chk("float_out_2", 64'(f2o[d]), 64'(ex.f2));
    if (!ex.err) chk("E_out_mul", 64'(eo[d]), 64'(ex.e));
    for (int i = 0; i < ex.hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_hold", {rdy[d], bpo[d], mo[d] == ex.m, erro[d] == ex.err, f2o[d] == ex.f2},
          {1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
    end
    bp[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("after_transfer", {rdy[d], erro[d], bpo[d]}, {1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; fa[d] = '0; fb[d] = '0; f2i[d] = '0; ei[d] = 1'b0; bp[d] = 1'b1;
    end
    tbl[0] = mk(31'h3F800000, 31'h3F800000, 1'b0, 48'h4000_0000_0000, 8'd0,   1'b0, 0);
    tbl[1] = mk(31'h40000000, 31'h3FC00000, 1'b0, 48'h6000_0000_0000, 8'd1,   1'b0, 0);
    tbl[2] = mk(31'h3FC00000, 31'h3FC00000, 1'b0, 48'h9000_0000_0000, 8'd0,   1'b0, 5);
    tbl[3] = mk(31'h00000000, 31'h3F800000, 1'b0, 48'h4000_0000_0000, 8'd0,   1'b1, 0);
    tbl[4] = mk(31'h3F800000, 31'h3F800000, 1'b1, 48'h4000_0000_0000, 8'd0,   1'b1, 0);
    tbl[5] = mk(31'h40400000, 31'h40A00000, 1'b0, 48'h7800_0000_0000, 8'd3,   1'b0, 0);
    tbl[6] = mk(31'h5F800000, 31'h5F800000, 1'b0, 48'h4000_0000_0000, 8'd0,   1'b1, 0);
    tbl[7] = mk(31'h7E800000, 31'h3F800000, 1'b0, 48'h4000_0000_0000, 8'h7E,  1'b0, 2);
    tbl[8] = mk(31'h00800000, 31'h3F800000, 1'b0, 48'h4000_0000_0000, 8'h82,  1'b0, 0);
    tbl[9] = mk(31'h7F800000, 31'h3F800000, 1'b0, 48'h4000_0000_0000, 8'd0,   1'b1, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {rdy[0], erro[0], bpo[0], mo[0], eo[0], f2o[0]},
        {1'b0, 1'b0, 1'b1, 48'd0, 8'd0, 31'd0});

    // Directed radix-1 vectors
    for (int i = 0; i < 10; i++) run(0, tbl[i], 24);

    // Reset pulse three cycles into BUSY must wipe everything
    @(negedge clk);
    fa[0] = 31'h3FC00000; fb[0] = 31'h3FC00000; f2i[0] = 31'h1234567; vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_midop", {rdy[0], erro[0], bpo[0], mo[0], eo[0], f2o[0]},
        {1'b0, 1'b0, 1'b1, 48'd0, 8'd0, 31'd0});
    @(negedge clk);
    rst = 1'b0;
    run(0, tbl[5], 24);

    // Radix-4 random legal operands with random downstream stalls
    for (int i = 0; i < 200; i++) begin
      vec_t v;
      int ea, eb;
      logic [22:0] ma, mb;
      logic [47:0] xa, xb;
      ea = $urandom_range(64, 190);
      eb = $urandom_range(64, 190);
      ma = 23'($urandom);
      mb = 23'($urandom);
      xa = {24'd0, 1'b1, ma};
      xb = {24'd0, 1'b1, mb};
      v = mk({8'(ea), ma}, {8'(eb), mb}, 1'b0, xa * xb, 8'(ea + eb - 254), 1'b0,
             int'($urandom_range(0, 3)));
      run(1, v, 6);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
